// File: rtl/uart_rx_cfg_if.sv
// Host-side read interface of the configurable UART receiver: FIFO head, status and pop/clear.
interface uart_rx_cfg_if #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned FIFO_W = 2
);
  logic              rd_uart;
  logic              clr_ovr;
  logic [DBIT-1:0]   rd_data;
  logic              rd_par_err;
  logic              rd_frm_err;
  logic              rx_empty;
  logic              rx_full;
  logic [FIFO_W:0]   rx_level;
  logic              rx_done;
  logic              overrun;

  modport master (
    output rd_uart, clr_ovr,
    input  rd_data, rd_par_err, rd_frm_err, rx_empty, rx_full, rx_level, rx_done, overrun
  );

  modport slave (
    input  rd_uart, clr_ovr,
    output rd_data, rd_par_err, rd_frm_err, rx_empty, rx_full, rx_level, rx_done, overrun
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime baud/parity, 16x oversampling and a show-ahead receive FIFO.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote at ticks 14/15/16 instead of a single s==15 sample.
module uart_rx_cfg #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned FIFO_W = 2,
  parameter int unsigned DVSR_W = 11,
  parameter int unsigned OS     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              par_en,
  input  logic              par_odd,
  uart_rx_cfg_if.slave      host
);

  localparam int unsigned Depth = 2 ** FIFO_W;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  localparam logic [4:0] MidS = 5'(OS / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
  // Decision lands on the first tick of the next bit, so the next bit resumes at s==1.
  localparam logic [4:0] SampleS  = 5'(OS);
  localparam logic [4:0] RestartS = 5'd1;
`else
  localparam logic [4:0] SampleS  = 5'(OS - 1);
  localparam logic [4:0] RestartS = 5'd0;
`endif

  logic              rx_meta, rxs;
  logic [DVSR_W-1:0] tick_cnt_q, dvsr_q, lim_m1;
  logic              tick;
  logic [2:0]        state_q, state_d;
  logic [4:0]        s_q, s_d;
  logic [2:0]        n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic              par_err_q, par_err_d;
  logic              par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic              bit_val, stop_fire, frm_err, done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Divisor is latched at each wrap so a change only affects the following period.
  assign lim_m1 = (dvsr_q == '0) ? '0 : dvsr_q - DVSR_W'(1);
  assign tick   = (tick_cnt_q == lim_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      dvsr_q     <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
      dvsr_q     <= dvsr;
    end else begin
      tick_cnt_q <= tick_cnt_q + DVSR_W'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s14_q, s15_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s14_q <= 1'b1;
      s15_q <= 1'b1;
    end else if (tick) begin
      if (s_q == 5'(OS - 2)) s14_q <= rxs;
      if (s_q == 5'(OS - 1)) s15_q <= rxs;
    end
  end
  assign bit_val = (s14_q & s15_q) | (s14_q & rxs) | (s15_q & rxs);
`else
  assign bit_val = rxs;
`endif

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    par_err_d = par_err_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop_fire = 1'b0;
    frm_err   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == MidS) begin
            if (!rxs) begin
              state_d   = StData;
              s_d       = '0;
              n_d       = '0;
              par_en_d  = par_en;
              par_odd_d = par_odd;
              par_err_d = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == SampleS) begin
            b_d = {bit_val, b_q[DBIT-1:1]};
            s_d = RestartS;
            if (n_q == 3'(DBIT - 1)) state_d = par_en_q ? StParity : StStop;
            else                     n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          if (s_q == SampleS) begin
            par_err_d = bit_val ^ (^b_q) ^ par_odd_q;
            s_d       = RestartS;
            state_d   = StStop;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (s_q == SampleS) begin
            stop_fire = 1'b1;
            frm_err   = ~bit_val;
            state_d   = frm_err ? StBreak : StIdle;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StBreak: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      par_err_q <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      par_err_q <= par_err_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      done_q    <= stop_fire;
    end
  end

  // Receive FIFO: entry = {frm_err, par_err, data}.
  logic [DBIT+1:0]   mem [Depth];
  logic [FIFO_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_W:0]   level_q, level_d;
  logic              empty, full, pop_ok, push_ok, ovr_set, ovr_q;
  logic [DBIT+1:0]   head;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (FIFO_W + 1)'(Depth));
  assign pop_ok  = host.rd_uart & ~empty;
  assign push_ok = stop_fire & (~full | pop_ok);
  assign ovr_set = stop_fire & full & ~pop_ok;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok)      level_d = level_q + (FIFO_W + 1)'(1);
    else if (!push_ok && pop_ok) level_d = level_q - (FIFO_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {frm_err, par_err_q, b_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + FIFO_W'(1);
      level_q <= level_d;
      if (ovr_set)           ovr_q <= 1'b1;
      else if (host.clr_ovr) ovr_q <= 1'b0;
    end
  end

  assign head            = mem[rd_ptr_q];
  assign host.rd_data    = empty ? '0 : head[DBIT-1:0];
  assign host.rd_par_err = empty ? 1'b0 : head[DBIT];
  assign host.rd_frm_err = empty ? 1'b0 : head[DBIT+1];
  assign host.rx_empty   = empty;
  assign host.rx_full    = full;
  assign host.rx_level   = level_q;
  assign host.rx_done    = done_q;
  assign host.overrun    = ovr_q;

endmodule
